stream_demux: RTL and testbench

- Registered 1-to-2 stream demultiplexer; counterpart of the combinational 2:1 select mux.
- Routes each beat of one valid/ready input stream to output 0 or output 1 according to a per-beat select.
- Each output has a 2-entry FIFO, so one stalled consumer never corrupts data and only blocks beats addressed to it.
- Sits between a single producer (bus/port model) and two consumers in the emulated-chip datapath.

---
 rtl/stream_demux.sv | 135 +++++++++++++
 tb/tb_stream_demux.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// Registered 1-to-2 stream demultiplexer with a 2-entry FIFO per output.
// Optional per-output pop counters are enabled with STREAM_DEMUX_BEAT_COUNT_EN.

module stream_demux_fifo2 #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [data_width-1:0] data,
    output logic                  valid,
    output logic                  full,
    output logic [data_width-1:0] head
);

    logic [1:0]            count;
    logic [data_width-1:0] tail;

    // Head always sits in 'head'; vacated slots are zeroed so an empty FIFO presents 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= data;
                    else               tail <= data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    tail  <= '0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= data;
                    end else begin
                        head <= data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign full  = (count == 2'd2);

endmodule

module stream_demux #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sel,
    input  logic [data_width-1:0] in_data,
    output logic                  out0_valid,
    input  logic                  out0_ready,
    output logic [data_width-1:0] out0_data,
    output logic                  out1_valid,
    input  logic                  out1_ready,
    output logic [data_width-1:0] out1_data
`ifdef STREAM_DEMUX_BEAT_COUNT_EN
    ,
    output logic [15:0]           beats0,
    output logic [15:0]           beats1
`endif
);

    logic pop0, pop1;
    logic push0, push1;
    logic full0, full1;
    logic room0, room1;

    assign pop0 = out0_valid & out0_ready;
    assign pop1 = out1_valid & out1_ready;

    // A full FIFO still has room when its head leaves in the same cycle.
    assign room0 = ~full0 | pop0;
    assign room1 = ~full1 | pop1;

    assign in_ready = in_sel ? room1 : room0;

    assign push0 = in_valid & in_ready & ~in_sel;
    assign push1 = in_valid & in_ready &  in_sel;

    stream_demux_fifo2 #(
        .data_width(data_width)
    ) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .pop   (pop0),
        .data  (in_data),
        .valid (out0_valid),
        .full  (full0),
        .head  (out0_data)
    );

    stream_demux_fifo2 #(
        .data_width(data_width)
    ) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .pop   (pop1),
        .data  (in_data),
        .valid (out1_valid),
        .full  (full1),
        .head  (out1_data)
    );

`ifdef STREAM_DEMUX_BEAT_COUNT_EN
    // Free-running pop counters; wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats0 <= 16'd0;
            beats1 <= 16'd0;
        end else begin
            if (pop0) beats0 <= beats0 + 16'd1;
            if (pop1) beats1 <= beats1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus random streaming
// checked every cycle against a queue-based reference model.

module tb_stream_demux;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_sel;
    logic [DW-1:0] in_data;
    logic          out0_valid;
    logic          out0_ready;
    logic [DW-1:0] out0_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [DW-1:0] out1_data;
`ifdef STREAM_DEMUX_BEAT_COUNT_EN
    logic [15:0]   beats0;
    logic [15:0]   beats1;
`endif

    stream_demux #(.data_width(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data)
`ifdef STREAM_DEMUX_BEAT_COUNT_EN
        ,
        .beats0     (beats0),
        .beats1     (beats1)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: one queue per output plus pop counters.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [15:0]   b0 = 16'd0;
    logic [15:0]   b1 = 16'd0;
    int            acc_cnt = 0;
    int            pop_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] head_of(input int n);
        if (n == 0) return (q0.size() != 0) ? q0[0] : '0;
        return (q1.size() != 0) ? q1[0] : '0;
    endfunction

    // Called at a negedge with inputs already applied; checks, then advances one cycle.
    task automatic step();
        bit room0, room1, exp_rdy, p0, p1, acc;
        #1;
        room0   = (q0.size() != 2) || out0_ready;
        room1   = (q1.size() != 2) || out1_ready;
        exp_rdy = in_sel ? room1 : room0;
        chk("in_ready",   in_ready,   exp_rdy);
        chk("out0_valid", out0_valid, q0.size() != 0);
        chk("out0_data",  out0_data,  head_of(0));
        chk("out1_valid", out1_valid, q1.size() != 0);
        chk("out1_data",  out1_data,  head_of(1));
`ifdef STREAM_DEMUX_BEAT_COUNT_EN
        chk("beats0", beats0, b0);
        chk("beats1", beats1, b1);
`endif
        p0  = (q0.size() != 0) && out0_ready;
        p1  = (q1.size() != 0) && out1_ready;
        acc = in_valid && exp_rdy;
        if (in_valid && in_ready) acc_cnt++;
        if (out0_valid && out0_ready) pop_cnt++;
        if (out1_valid && out1_ready) pop_cnt++;
        @(posedge clk);
        if (p0) begin void'(q0.pop_front()); b0 = b0 + 16'd1; end
        if (p1) begin void'(q1.pop_front()); b1 = b1 + 16'd1; end
        if (acc) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit s, input logic [DW-1:0] d,
                         input bit r0, input bit r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        b0 = 16'd0;
        b1 = 16'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, '0, 0, 0);
        @(negedge clk);
        #1;
        chk("rst_out0_valid", out0_valid, 1'b0);
        chk("rst_out1_valid", out1_valid, 1'b0);
        chk("rst_out0_data",  out0_data,  '0);
        chk("rst_in_ready",   in_ready,   1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic routing
        drive(1, 0, 32'hA5A5A5A5, 1, 1); step();
        drive(1, 1, 32'h5A5A5A5A, 1, 1);
        #1;
        chk("route0_valid", out0_valid, 1'b1);
        chk("route0_data",  out0_data,  32'hA5A5A5A5);
        chk("route0_other", out1_valid, 1'b0);
        step();
        drive(0, 0, '0, 1, 1);
        #1;
        chk("route1_valid", out1_valid, 1'b1);
        chk("route1_data",  out1_data,  32'h5A5A5A5A);
        chk("route1_other", out0_valid, 1'b0);
        step();

        // Full / backpressure on output 0
        drive(1, 0, 32'h1, 0, 0); step();
        drive(1, 0, 32'h2, 0, 0); step();
        drive(1, 0, 32'h3, 0, 0);
        #1;
        chk("full_in_ready", in_ready,  1'b0);
        chk("full_head",     out0_data, 32'h1);
        step();
        drive(1, 0, 32'h3, 1, 0);
        #1;
        chk("popfull_in_ready", in_ready, 1'b1);
        step();
        drive(0, 0, '0, 1, 0);
        #1;
        chk("seq_2", out0_data, 32'h2);
        step();
        #1;
        chk("seq_3", out0_data, 32'h3);
        step();
        step();

        // No head-of-line blocking
        drive(1, 0, 32'h10, 0, 0); step();
        drive(1, 0, 32'h11, 0, 0); step();
        drive(1, 1, 32'h77, 0, 0);
        #1;
        chk("hol_in_ready", in_ready, 1'b1);
        step();
        drive(0, 0, '0, 0, 0);
        #1;
        chk("hol_out1_valid", out1_valid, 1'b1);
        chk("hol_out1_data",  out1_data,  32'h77);
        chk("hol_out0_full",  out0_data,  32'h10);
        step();

        // Reset mid-stream with FIFO0 holding two beats
        drive(0, 0, '0, 0, 1); step();
        rst_n = 1'b0;
        #1;
        chk("midrst_out0_valid", out0_valid, 1'b0);
        chk("midrst_out1_valid", out1_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, '0, 1, 1);
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        step();
        drive(1, 0, 32'hBEEF, 1, 1); step();
        drive(0, 0, '0, 1, 1);
        #1;
        chk("midrst_next_beat", out0_data, 32'hBEEF);
        step();
        step();

        // Random streaming
        acc_cnt = 0;
        pop_cnt = 0;
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1));
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0, 1, 1);
            step();
        end
        chk("conservation", acc_cnt, pop_cnt);
        chk("drained", {out1_valid, out0_valid}, 2'b00);

`ifdef STREAM_DEMUX_BEAT_COUNT_EN
        begin
            logic [15:0] snap0;
            rst_n = 1'b0;
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
            drive(0, 0, '0, 0, 0);
            step();
            snap0 = b0;
            while (b1 != 16'd65534) begin
                drive(1, 1, $urandom, 0, 1);
                step();
            end
            #1;
            chk("cnt_preload", beats1, 16'hFFFE);
            drive(1, 1, $urandom, 0, 1); step();
            #1; chk("cnt_ffff", beats1, 16'hFFFF);
            drive(1, 1, $urandom, 0, 1); step();
            #1; chk("cnt_wrap", beats1, 16'h0000);
            drive(1, 1, $urandom, 0, 1); step();
            #1; chk("cnt_one", beats1, 16'h0001);
            chk("cnt_beats0", beats0, snap0);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
